// File: rtl/bcd_adder.sv
// bcd_adder: registered ripple-carry BCD adder with an invalid-digit flag
module bcd_adder #(
    parameter int DIGITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic [4*DIGITS-1:0] sum,
    output logic                finalcarry,
    output logic                out_valid,
    output logic                err
);
    logic [4*DIGITS-1:0] raw, sum_d, sum_q;
    logic                fc_d, fc_q, err_d, err_q, ov_q;
    logic [4:0]          t;
    logic [3:0]          da, db;
    logic                cy;

    // ripple the decimal-corrected digit adders; a non-BCD operand digit zeroes the result
    always_comb begin
        cy    = cin;
        err_d = 1'b0;
        raw   = '0;
        t     = '0;
        da    = '0;
        db    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            da    = a[4*i +: 4];
            db    = b[4*i +: 4];
            t     = {1'b0, da} + {1'b0, db} + {4'b0, cy};
            err_d = err_d | (da > 4'd9) | (db > 4'd9);
            raw[4*i +: 4] = (t > 5'd9) ? t[3:0] + 4'd6 : t[3:0];
            cy    = (t > 5'd9);
        end
        sum_d = err_d ? '0 : raw;
        fc_d  = cy & ~err_d;
    end

    // output stage: reset clears, in_valid captures, otherwise hold with out_valid low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            fc_q  <= 1'b0;
            err_q <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            ov_q <= in_valid;
            if (in_valid) begin
                sum_q <= sum_d;
                fc_q  <= fc_d;
                err_q <= err_d;
            end
        end
    end

    assign sum        = sum_q;
    assign finalcarry = fc_q;
    assign out_valid  = ov_q;
    assign err        = err_q;
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: directed vectors, corner sequences and random checks for 1- and 2-digit BCD adders
module tb_bcd_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v1, c1, f1, o1, e1;
    logic [3:0] a1, b1, s1;
    logic       v2, c2, f2, o2, e2;
    logic [7:0] a2, b2, s2;
    int         n_run = 0;
    int         n_fail = 0;

    typedef struct {
        int         dig;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        int         s;
        int         f;
        int         e;
    } vec_t;

    vec_t tv[9];

    always #5 clk = ~clk;

    bcd_adder #(.DIGITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .finalcarry(f1), .out_valid(o1), .err(e1)
    );

    bcd_adder #(.DIGITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .cin(c2),
        .sum(s2), .finalcarry(f2), .out_valid(o2), .err(e2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input int s, input int f, input int o, input int e);
        chk({nm, ".sum"}, 32'(s1), s);
        chk({nm, ".carry"}, 32'(f1), f);
        chk({nm, ".valid"}, 32'(o1), o);
        chk({nm, ".err"}, 32'(e1), e);
    endtask

    task automatic chk2(input string nm, input int s, input int f, input int o, input int e);
        chk({nm, ".sum2"}, 32'(s2), s);
        chk({nm, ".carry2"}, 32'(f2), f);
        chk({nm, ".valid2"}, 32'(o2), o);
        chk({nm, ".err2"}, 32'(e2), e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // decimal reference: {err, carry, packed BCD sum}
    function automatic logic [33:0] model(input int nd, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
        int         av, bv, da, db, s;
        logic       bad;
        logic [31:0] r;
        av = 0; bv = 0; bad = 1'b0; r = '0;
        for (int i = nd - 1; i >= 0; i--) begin
            da = int'((a >> (4 * i)) & 32'hF);
            db = int'((b >> (4 * i)) & 32'hF);
            if (da > 9 || db > 9) bad = 1'b1;
            av = av * 10 + da;
            bv = bv * 10 + db;
        end
        if (bad) return {1'b1, 1'b0, 32'h0};
        s = av + bv + int'(cin);
        for (int i = 0; i < nd; i++) begin
            r = r | (32'(s % 10) << (4 * i));
            s = s / 10;
        end
        return {1'b0, (s != 0), r};
    endfunction

    function automatic logic [7:0] rdig(input int nd);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < nd; i++)
            r[4*i +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        logic [33:0] m1, m2, x1, x2;
        logic        xo1, xo2;
        tv[0] = '{1, 8'h09, 8'h09, 1'b0, 'h8, 1, 0};
        tv[1] = '{1, 8'h05, 8'h05, 1'b0, 'h0, 1, 0};
        tv[2] = '{1, 8'h09, 8'h09, 1'b1, 'h9, 1, 0};
        tv[3] = '{1, 8'h07, 8'h06, 1'b0, 'h3, 1, 0};
        tv[4] = '{1, 8'h0C, 8'h03, 1'b0, 'h0, 0, 1};
        tv[5] = '{1, 8'h02, 8'h02, 1'b0, 'h4, 0, 0};
        tv[6] = '{2, 8'h99, 8'h01, 1'b0, 'h00, 1, 0};
        tv[7] = '{2, 8'h45, 8'h38, 1'b0, 'h83, 0, 0};
        tv[8] = '{2, 8'h99, 8'h99, 1'b1, 'h99, 1, 0};

        v1 = 1'b1; a1 = 4'd9; b1 = 4'd9; c1 = 1'b0;
        v2 = 1'b1; a2 = 8'h99; b2 = 8'h99; c2 = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk1("reset", 0, 0, 0, 0);
        chk2("reset", 0, 0, 0, 0);
        rst_n = 1'b1; v2 = 1'b0; a1 = 4'd5; b1 = 4'd4;
        step();
        chk1("5+4", 9, 0, 1, 0);

        for (int i = 0; i < 9; i++) begin
            v1 = (tv[i].dig == 1); v2 = (tv[i].dig == 2);
            a1 = tv[i].a[3:0]; b1 = tv[i].b[3:0]; c1 = tv[i].cin;
            a2 = tv[i].a; b2 = tv[i].b; c2 = tv[i].cin;
            step();
            if (tv[i].dig == 1) chk1($sformatf("vec%0d", i), tv[i].s, tv[i].f, 1, tv[i].e);
            else chk2($sformatf("vec%0d", i), tv[i].s, tv[i].f, 1, tv[i].e);
        end

        v2 = 1'b0; v1 = 1'b1; c1 = 1'b0;
        for (int a = 0; a < 10; a++)
            for (int b = 0; b < 10; b++) begin
                a1 = 4'(a); b1 = 4'(b);
                step();
                chk1($sformatf("exh%0d+%0d", a, b), (a + b) % 10, int'(a + b >= 10), 1, 0);
            end

        a1 = 4'd3; b1 = 4'd4;
        step();
        chk1("hold0", 7, 0, 1, 0);
        v1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = 4'($urandom); b1 = 4'($urandom); c1 = 1'($urandom);
            step();
            chk1($sformatf("hold%0d", i + 1), 7, 0, 0, 0);
        end

        v1 = 1'b1; a1 = 4'd12; b1 = 4'd3; c1 = 1'b0;
        step();
        chk1("bad", 0, 0, 1, 1);
        v1 = 1'b0;
        step();
        chk1("badhold", 0, 0, 0, 1);

        v1 = 1'b1; a1 = 4'd8; b1 = 4'd1;
        step();
        chk1("8+1", 9, 0, 1, 0);
        a1 = 4'd2; b1 = 4'd2; rst_n = 1'b0;
        step();
        chk1("midrst", 0, 0, 0, 0);
        v1 = 1'b0; v2 = 1'b0;
        step();
        rst_n = 1'b1;

        x1 = '0; x2 = '0; xo1 = 1'b0; xo2 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v1 = ($urandom_range(0, 3) != 0); a1 = rdig(1)[3:0]; b1 = rdig(1)[3:0]; c1 = 1'($urandom);
            v2 = ($urandom_range(0, 3) != 0); a2 = rdig(2); b2 = rdig(2); c2 = 1'($urandom);
            m1 = model(1, 32'(a1), 32'(b1), c1);
            m2 = model(2, 32'(a2), 32'(b2), c2);
            step();
            if (v1) x1 = m1;
            if (v2) x2 = m2;
            xo1 = v1; xo2 = v2;
            chk1($sformatf("rnd%0d", i), int'(x1[31:0]), int'(x1[32]), int'(xo1), int'(x1[33]));
            chk2($sformatf("rnd%0d", i), int'(x2[31:0]), int'(x2[32]), int'(xo2), int'(x2[33]));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_adder.md
Name: bcd_adder

Overview:
- Registered BCD adder: adds two packed BCD operands plus a carry-in, producing a BCD sum and a decimal carry-out.
- Datapath arithmetic block used wherever decimal digit arithmetic is required.
- Ripple of per-digit decimal-corrected adders (binary add, +6 correction when the digit result exceeds 9), followed by one output register stage.
- Default configuration is a single digit (4-bit operands).

Parameters:
- DIGITS, 1, number of BCD digits per operand; legal range 1..8; operand width = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  qualifies a, b, cin for capture this cycle.
- a  input  4*DIGITS  BCD operand A; digit i occupies bits [4i+3:4i].
- b  input  4*DIGITS  BCD operand B, same packing.
- cin  input  1  decimal carry-in into digit 0; tie 0 for plain a+b.
- sum  output  4*DIGITS  registered BCD sum, same packing.
- finalcarry  output  1  registered decimal carry-out of the most significant digit.
- out_valid  output  1  high for one cycle per accepted input, aligned with sum/finalcarry.
- err  output  1  registered flag: some digit of the accepted a or b was greater than 9.

Behaviour:
- Reset: on a rising clk with rst_n=0, sum=0, finalcarry=0, out_valid=0, err=0. Reset has priority over in_valid on the same edge. An operation in flight is discarded.
- Per-digit rule (combinational), digits i=0..DIGITS-1, c0=cin:
  - t = a_i + b_i + c_i, computed 5 bits wide.
  - If t > 9: s_i = (t + 6) mod 16 and c_(i+1) = 1.
  - Otherwise: s_i = t and c_(i+1) = 0.
  - finalcarry source = c_DIGITS.
- Capture: on a rising clk with rst_n=1 and in_valid=1:
  - sum and finalcarry load the computed result.
  - err loads the OR of (digit > 9) over all digits of a and b.
  - out_valid is set to 1.
- Invalid digits: when err is set, sum and finalcarry are forced to 0 for that result, and out_valid is still asserted.
- Idle: on a rising clk with rst_n=1 and in_valid=0, out_valid=0. sum, finalcarry and err hold their previous values.
- Latency: exactly 1 cycle from the in_valid edge to out_valid. Full throughput: one new operation may be accepted every cycle, with no backpressure.
- Range: maximum single-digit case is 9+9+1 = 19, giving s=9 and carry=1. Results are always valid BCD for valid inputs.
- No X propagation from a, b or cin when in_valid=0; outputs are unaffected.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=9, b=9 -> sum=0, finalcarry=0, out_valid=0, err=0. Release reset, apply 5+4 (cin=0) -> next cycle sum=9, finalcarry=0, out_valid=1.
- Carry correction, DIGITS=1:
  - 9+9 cin=0 -> sum=8, finalcarry=1.
  - 5+5 -> sum=0, finalcarry=1.
  - 9+9 cin=1 -> sum=9, finalcarry=1.
- Exhaustive, DIGITS=1: every a=0..9 against every b=0..9, one per cycle, cin=0 -> {finalcarry,sum} equals the decimal a+b each cycle (e.g. 7+6 -> 1,3), with out_valid continuously 1.
- Invalid digit: a=12, b=3 -> err=1, sum=0, finalcarry=0, out_valid=1. Following 2+2 -> err=0, sum=4.
- Hold/valid gap: accept 3+4, then drop in_valid for 3 cycles -> sum stays 7 and out_valid pulses for exactly one cycle. Asserting rst_n=0 mid-stream clears the outputs on the next edge.
- Multi-digit, DIGITS=2: a=0x99, b=0x01, cin=0 -> sum=0x00, finalcarry=1. a=0x45, b=0x38 -> sum=0x83, finalcarry=0.
